// File: rtl/conv_collector_pkg.sv
// conv_collector_pkg
//   Shared constants for the conv output collector: the frame-info field
//   layout and the collector FSM state encoding.
package conv_collector_pkg;

   // frame info layout: [4:0] shift, [5] relu enable, upper bits reserved
   localparam int INFO_SHIFT_LSB = 0;
   localparam int INFO_SHIFT_W   = 5;
   localparam int INFO_RELU_BIT  = 5;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } coll_state_e;

endpackage

// File: rtl/conv_requant.sv
// conv_requant
//   Requantizes one signed OW-bit accumulator value to a signed DW-bit element.
//   Stage 1 (registered): round-half-up and arithmetic right shift.
//   Stage 2 (registered): optional ReLU, then saturation to the DW range.
// Ports
//   clk, rst_n   clock, async active-low reset
//   x_i          signed OW-bit input element
//   shift_i      right shift amount (values >= OW clamp to OW-1)
//   relu_i       clamp negatives to zero
//   y_o          signed DW-bit result, two cycles after x_i
module conv_requant
   import conv_collector_pkg::*;
#(
   parameter int DW = 8,
   parameter int OW = 22
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [OW-1:0]           x_i,
   input  logic [INFO_SHIFT_W-1:0] shift_i,
   input  logic                    relu_i,
   output logic [DW-1:0]           y_o
);

   localparam logic signed [OW:0] MAXV = (OW+1)'((2 ** (DW-1)) - 1);
   localparam logic signed [OW:0] MINV = -((OW+1)'(2 ** (DW-1)));

   logic [INFO_SHIFT_W-1:0] sh;
   logic signed [OW:0]      xe, rnd, sum, shd_d, shd_q;
   logic                    relu_q;
   logic [DW-1:0]           y_d, y_q;

   // Round constant is added in OW+1 bits so it can never overflow.
   always_comb begin
      sh    = (shift_i >= INFO_SHIFT_W'(OW)) ? INFO_SHIFT_W'(OW-1) : shift_i;
      xe    = {x_i[OW-1], x_i};
      rnd   = (sh == '0) ? '0 : ((OW+1)'(1) << (sh - 1'b1));
      sum   = xe + rnd;
      shd_d = sum >>> sh;
   end

   always_comb begin
      y_d = shd_q[DW-1:0];
      if (relu_q && shd_q[OW])
         y_d = '0;
      else if (shd_q > MAXV)
         y_d = MAXV[DW-1:0];
      else if (shd_q < MINV)
         y_d = MINV[DW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_q  <= '0;
         relu_q <= 1'b0;
         y_q    <= '0;
      end else begin
         shd_q  <= shd_d;
         relu_q <= relu_i;
         y_q    <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/conv_collector.sv
// conv_collector
//   Consumes the distributer's per-beat accumulated column stream, requantizes
//   every column to DW bits and writes one packed word per beat to the ofmap
//   SRAM at base+beat_index. Writes, done and err emerge two cycles after the
//   beat that caused them.
// Ports
//   clk, rst_n            clock, async active-low reset
//   s_data/s_valid/s_first input beat stream (COLUMN x OW bits)
//   s_info/s_base/s_size  frame parameters, sampled on the first beat
//   wr_en/wr_addr/wr_data SRAM write port
//   done                  pulse with the last write of a frame
//   err                   pulse on a protocol violation
module conv_collector
   import conv_collector_pkg::*;
#(
   parameter int DW     = 8,
   parameter int OW     = 22,
   parameter int COLUMN = 6,
   parameter int INFOW2 = 28,
   parameter int AW     = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OW*COLUMN-1:0] s_data,
   input  logic                 s_valid,
   input  logic                 s_first,
   input  logic [INFOW2-1:0]    s_info,
   input  logic [AW-1:0]        s_base,
   input  logic [AW-1:0]        s_size,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW*COLUMN-1:0] wr_data,
   output logic                 done,
   output logic                 err
);

   coll_state_e             state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d, base_q, base_d, size_q, size_d, idx;
   logic [INFO_SHIFT_W-1:0] shift_q, shift_d, shift_use;
   logic                    relu_q, relu_d, relu_use;
   logic                    start, wr1, done1, err1;
   // side-band pipeline: [0] = stage 1, [1] = output stage
   logic [1:0]              wr_pipe_q, done_pipe_q, err_pipe_q;
   logic [1:0][AW-1:0]      addr_pipe_q;
   logic                    unused_info;

   assign unused_info = ^s_info[INFOW2-1:INFO_RELU_BIT+1];

   // A first beat always starts a frame, even mid-frame (abort).
   assign start     = s_valid & s_first;
   assign shift_use = start ? s_info[INFO_SHIFT_LSB +: INFO_SHIFT_W] : shift_q;
   assign relu_use  = start ? s_info[INFO_RELU_BIT] : relu_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      size_d  = size_q;
      shift_d = shift_q;
      relu_d  = relu_q;
      idx     = '0;
      wr1     = 1'b0;
      done1   = 1'b0;
      err1    = 1'b0;
      if (start) begin
         err1    = (state_q == COLLECT) || (s_size == '0);
         base_d  = s_base;
         size_d  = s_size;
         shift_d = shift_use;
         relu_d  = relu_use;
         cnt_d   = AW'(1);
         wr1     = (s_size != '0);
         // size 0 or 1 frames complete on this beat
         if (s_size <= AW'(1)) begin
            done1   = 1'b1;
            state_d = IDLE;
         end else begin
            state_d = COLLECT;
         end
      end else if (s_valid) begin
         if (state_q == IDLE) begin
            err1 = 1'b1;
         end else begin
            wr1   = 1'b1;
            idx   = cnt_q;
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == size_q - AW'(1)) begin
               done1   = 1'b1;
               state_d = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         base_q      <= '0;
         size_q      <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         wr_pipe_q   <= '0;
         done_pipe_q <= '0;
         err_pipe_q  <= '0;
         addr_pipe_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         base_q         <= base_d;
         size_q         <= size_d;
         shift_q        <= shift_d;
         relu_q         <= relu_d;
         wr_pipe_q      <= {wr_pipe_q[0], wr1};
         done_pipe_q    <= {done_pipe_q[0], done1};
         err_pipe_q     <= {err_pipe_q[0], err1};
         // address wraps mod 2^AW by width truncation
         addr_pipe_q[0] <= (start ? s_base : base_q) + idx;
         addr_pipe_q[1] <= addr_pipe_q[0];
      end
   end

   for (genvar c = 0; c < COLUMN; c++) begin : g_col
      conv_requant #(.DW(DW), .OW(OW)) u_rq (
         .clk     (clk),
         .rst_n   (rst_n),
         .x_i     (s_data[c*OW +: OW]),
         .shift_i (shift_use),
         .relu_i  (relu_use),
         .y_o     (wr_data[c*DW +: DW])
      );
   end

   assign wr_en   = wr_pipe_q[1];
   assign wr_addr = addr_pipe_q[1];
   assign done    = done_pipe_q[1];
   assign err     = err_pipe_q[1];

endmodule

// File: tb/tb_conv_collector.sv
module tb_conv_collector;
   localparam int DW = 8, OW = 22, COLUMN = 6, INFOW2 = 28, AW = 10;

   typedef struct {
      int                      due;
      logic [AW-1:0]           addr;
      logic [DW*COLUMN-1:0]    data;
   } wr_exp_t;

   logic                 clk = 1'b0, rst_n = 1'b0;
   logic [OW*COLUMN-1:0] s_data = '0;
   logic                 s_valid = 1'b0, s_first = 1'b0;
   logic [INFOW2-1:0]    s_info = '0;
   logic [AW-1:0]        s_base = '0, s_size = '0;
   logic                 wr_en, done, err;
   logic [AW-1:0]        wr_addr;
   logic [DW*COLUMN-1:0] wr_data;

   conv_collector #(.DW(DW), .OW(OW), .COLUMN(COLUMN), .INFOW2(INFOW2), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_first(s_first),
      .s_info(s_info), .s_base(s_base), .s_size(s_size), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err));

   always #5 clk = ~clk;

   int      n_cmp = 0, n_bad = 0, cyc = 0;
   wr_exp_t wq[$];
   int      dq[$], eq[$];
   int      col[COLUMN];
   // reference frame state
   bit      m_active = 0;
   int      m_base, m_size, m_cnt, m_shift;
   bit      m_relu;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rq(input int x, input int sh, input bit relu);
      longint s;
      if (sh > OW - 1) sh = OW - 1;
      s = x;
      if (sh > 0) s = s + (longint'(1) << (sh - 1));
      s = s >>> sh;
      if (relu && s < 0) s = 0;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s[DW-1:0];
   endfunction

   // monitor: every cycle, outputs must match what the scoreboard expects now
   initial forever begin
      @(negedge clk);
      cyc++;
      begin
         bit ew, ed, ee;
         ew = (wq.size() > 0) && (wq[0].due == cyc);
         ed = (dq.size() > 0) && (dq[0] == cyc);
         ee = (eq.size() > 0) && (eq[0] == cyc);
         check("wr_en", 64'(wr_en), 64'(ew));
         check("done", 64'(done), 64'(ed));
         check("err", 64'(err), 64'(ee));
         if (ew && wr_en) begin
            check("wr_addr", 64'(wr_addr), 64'(wq[0].addr));
            check("wr_data", 64'(wr_data), 64'(wq[0].data));
         end
         while (wq.size() > 0 && wq[0].due <= cyc) void'(wq.pop_front());
         while (dq.size() > 0 && dq[0] <= cyc) void'(dq.pop_front());
         while (eq.size() > 0 && eq[0] <= cyc) void'(eq.pop_front());
      end
   end

   task automatic push_wr(input int idx);
      wr_exp_t e;
      e.due  = cyc + 2;
      e.addr = AW'(m_base + idx);
      for (int c = 0; c < COLUMN; c++) e.data[c*DW +: DW] = rq(col[c], m_shift, m_relu);
      wq.push_back(e);
   endtask

   // one clock of stimulus; the reference model predicts the outputs
   task automatic beat(input bit v, input bit f, input int base, input int size,
                       input int shift, input bit relu);
      logic [OW*COLUMN-1:0] sd;
      bit e;
      @(negedge clk); #1;
      for (int c = 0; c < COLUMN; c++) sd[c*OW +: OW] = col[c][OW-1:0];
      s_data = sd; s_valid = v; s_first = f;
      s_info = INFOW2'({relu, shift[4:0]}) | (INFOW2'(1) << 20); // reserved bit set
      s_base = AW'(base); s_size = AW'(size);
      e = 0;
      if (v && f) begin
         e = m_active;
         m_base = base; m_size = size; m_shift = shift; m_relu = relu; m_cnt = 0;
         m_active = 0;
         if (size == 0) begin
            e = 1; dq.push_back(cyc + 2);
         end else begin
            push_wr(0); m_cnt = 1;
            if (size == 1) dq.push_back(cyc + 2); else m_active = 1;
         end
      end else if (v) begin
         if (!m_active) e = 1;
         else begin
            push_wr(m_cnt); m_cnt++;
            if (m_cnt == m_size) begin dq.push_back(cyc + 2); m_active = 0; end
         end
      end
      if (e) eq.push_back(cyc + 2);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, 0);
   endtask

   task automatic setcols(input int a, input int b, input int c, input int d,
                          input int e, input int f);
      col[0] = a; col[1] = b; col[2] = c; col[3] = d; col[4] = e; col[5] = f;
   endtask

   initial begin
      setcols(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("reset_outputs", {wr_en, done, err, 1'b0, wr_addr, 48'(wr_data)}, 64'd0);
      @(negedge clk); #1; rst_n = 1'b1;

      // 1: basic frame, shift 0, with a gap beat
      setcols(5, -3, 200, -200, 0, 127);   beat(1, 1, 100, 4, 0, 0);
      setcols(6, 1, -129, 128, -1, 2);     beat(1, 0, 0, 0, 0, 0);
      idle(1);
      setcols(7, 100, 50, -50, 3, 4);      beat(1, 0, 0, 0, 0, 0);
      setcols(8, -128, 127, 9, 9, 9);      beat(1, 0, 0, 0, 0, 0);
      idle(3);

      // 2: rounding shift and saturation
      setcols(24, -24, 4000, -4000, 8, -9); beat(1, 1, 10, 1, 4, 0);
      idle(3);
      // 3: relu with shift 2
      setcols(-100, 101, -1, 2, 510, -600); beat(1, 1, 20, 2, 2, 1);
      setcols(6, -6, 1, -2, 0, 511);        beat(1, 0, 0, 0, 0, 0);
      idle(3);
      // shift >= OW clamps to OW-1
      setcols(-2097152, 2097151, 1048576, -1048577, 5, -5); beat(1, 1, 30, 1, 31, 0);
      idle(3);

      // 4: address wrap
      setcols(1, 2, 3, 4, 5, 6);
      beat(1, 1, 1022, 4, 0, 0);
      for (int i = 0; i < 3; i++) begin col[0] = 10 + i; beat(1, 0, 0, 0, 0, 0); end
      idle(3);

      // 5: abort in mid-frame by a new first beat
      setcols(11, 12, 13, 14, 15, 16); beat(1, 1, 200, 10, 1, 0);
      beat(1, 0, 0, 0, 0, 0);
      beat(1, 0, 0, 0, 0, 0);
      setcols(-7, 7, -8, 8, 0, 1);     beat(1, 1, 0, 2, 0, 1);
      beat(1, 0, 0, 0, 0, 0);
      idle(3);

      // 6: orphan beat, empty frame, reset mid-frame
      beat(1, 0, 0, 0, 0, 0);
      idle(3);
      beat(1, 1, 50, 0, 0, 0);
      idle(3);
      beat(1, 1, 300, 5, 0, 0);
      beat(1, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      rst_n = 1'b0; s_valid = 1'b0; s_first = 1'b0;
      wq.delete(); dq.delete(); eq.delete(); m_active = 0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      beat(1, 0, 0, 0, 0, 0);          // no frame open after reset
      idle(3);
      setcols(33, 34, 35, 36, 37, 38); beat(1, 1, 400, 1, 0, 0);
      idle(5);

      check("sb_empty", 64'(wq.size() + dq.size() + eq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
